// File: rtl/floor_bcd_scorer.sv
// ---------------------------------------------------------------------------
// floor_bcd_scorer
//
// Score / floor-count stage that feeds the 4-digit seven-segment display
// driver. It turns game-event levels from the game controller into single
// events, keeps the running floor count and the best score as 4-digit packed
// BCD, and selects what the display shows. After game over the display
// alternates between the last score and the best score.
//
// Parameters:
//   ALT_PERIOD  clk cycles per half-period of the score/best alternation
//               in OVER (must be >= 2)
//
// Ports:
//   clk        in   1   system clock
//   rst        in   1   asynchronous active-low reset
//   start      in   1   start/restart request (rising edge acts)
//   floor_inc  in   1   one floor passed (rising edge acts)
//   game_over  in   1   player died (rising edge acts)
//   score_bcd  out  16  current score, packed BCD
//   best_bcd   out  16  best score since reset, packed BCD
//   cnt_data   out  16  digit bus to the display driver, [3:0] = units
//   state      out  2   00 IDLE, 01 PLAY, 10 OVER
//   sat        out  1   high while the score is held at 9999
// ---------------------------------------------------------------------------
module floor_bcd_scorer #(
  parameter int ALT_PERIOD = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        floor_inc,
  input  logic        game_over,
  output logic [15:0] score_bcd,
  output logic [15:0] best_bcd,
  output logic [15:0] cnt_data,
  output logic [1:0]  state,
  output logic        sat
);

  localparam int CNT_W = $clog2(ALT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_OVER = 2'b10
  } state_t;

  state_t           r_state;
  logic [15:0]      r_score;
  logic [15:0]      r_best;
  logic [15:0]      r_cntData;
  logic             r_sat;
  logic [CNT_W-1:0] r_altCnt;
  logic             r_showBest;
  logic             r_startPrev;
  logic             r_incPrev;
  logic             r_overPrev;

  state_t           w_stateNext;
  logic [15:0]      w_scoreNext;
  logic [15:0]      w_bestNext;
  logic             w_satNext;
  logic [CNT_W-1:0] w_altCntNext;
  logic             w_showBestNext;
  logic [15:0]      w_scoreInc;
  logic [15:0]      w_dispSel;
  logic             w_startEv;
  logic             w_incEv;
  logic             w_overEv;

  // One-digit-at-a-time BCD increment: a 9 rolls to 0 and passes the carry
  // on, so every digit stays in 0-9. Saturation is handled by the caller.
  function automatic logic [15:0] bcdInc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    res   = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (v[d*4 +: 4] == 4'd9) begin
          res[d*4 +: 4] = 4'd0;
        end else begin
          res[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  // A level that was low last cycle and is high now is one event, so a
  // held input only ever counts once.
  assign w_startEv  = start & ~r_startPrev;
  assign w_incEv    = floor_inc & ~r_incPrev;
  assign w_overEv   = game_over & ~r_overPrev;
  assign w_scoreInc = bcdInc(r_score);

  // Next-state and next-value logic. Priority inside a cycle is
  // start > game_over > floor_inc; lower events are simply dropped.
  always_comb begin
    w_stateNext    = r_state;
    w_scoreNext    = r_score;
    w_bestNext     = r_best;
    w_satNext      = r_sat;
    w_altCntNext   = r_altCnt;
    w_showBestNext = r_showBest;
    case (r_state)
      S_IDLE: begin
        if (w_startEv) begin
          w_stateNext = S_PLAY;
          w_scoreNext = 16'h0000;
          w_satNext   = 1'b0;
        end
      end
      S_PLAY: begin
        if (w_startEv) begin
          w_scoreNext = 16'h0000;
          w_satNext   = 1'b0;
        end else if (w_overEv) begin
          w_stateNext    = S_OVER;
          w_altCntNext   = '0;
          w_showBestNext = 1'b0;
          // Packed BCD compares correctly as a plain unsigned number.
          if (r_score > r_best) begin
            w_bestNext = r_score;
          end
        end else if (w_incEv) begin
          if (r_score == 16'h9999) begin
            w_satNext = 1'b1;
          end else begin
            w_scoreNext = w_scoreInc;
            if (w_scoreInc == 16'h9999) begin
              w_satNext = 1'b1;
            end
          end
        end
      end
      S_OVER: begin
        if (w_startEv) begin
          w_stateNext    = S_PLAY;
          w_scoreNext    = 16'h0000;
          w_satNext      = 1'b0;
          w_altCntNext   = '0;
          w_showBestNext = 1'b0;
        end else if (r_altCnt == CNT_LAST) begin
          w_altCntNext   = '0;
          w_showBestNext = ~r_showBest;
        end else begin
          w_altCntNext = r_altCnt + CNT_W'(1);
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Display selection from the currently registered values; registering it
  // makes cnt_data trail the score/best/state outputs by one cycle.
  always_comb begin
    w_dispSel = r_best;
    case (r_state)
      S_PLAY:  w_dispSel = r_score;
      S_OVER:  w_dispSel = r_showBest ? r_best : r_score;
      default: w_dispSel = r_best;
    endcase
  end

  // State and data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_score     <= 16'h0000;
      r_best      <= 16'h0000;
      r_cntData   <= 16'h0000;
      r_sat       <= 1'b0;
      r_altCnt    <= '0;
      r_showBest  <= 1'b0;
      r_startPrev <= 1'b0;
      r_incPrev   <= 1'b0;
      r_overPrev  <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_score     <= w_scoreNext;
      r_best      <= w_bestNext;
      r_cntData   <= w_dispSel;
      r_sat       <= w_satNext;
      r_altCnt    <= w_altCntNext;
      r_showBest  <= w_showBestNext;
      r_startPrev <= start;
      r_incPrev   <= floor_inc;
      r_overPrev  <= game_over;
    end
  end

  assign score_bcd = r_score;
  assign best_bcd  = r_best;
  assign cnt_data  = r_cntData;
  assign state     = r_state;
  assign sat       = r_sat;

endmodule

// File: tb/tb_floor_bcd_scorer.sv
// ---------------------------------------------------------------------------
// tb_floor_bcd_scorer
//
// Directed bench for floor_bcd_scorer with ALT_PERIOD = 4. Inputs change
// 1 ns after a rising edge and outputs are sampled at that same point, so
// every check sees the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_floor_bcd_scorer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        floor_inc;
  logic        game_over;
  logic [15:0] score_bcd;
  logic [15:0] best_bcd;
  logic [15:0] cnt_data;
  logic [1:0]  state;
  logic        sat;

  int vectors;
  int miscompares;

  floor_bcd_scorer #(.ALT_PERIOD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .floor_inc (floor_inc),
    .game_over (game_over),
    .score_bcd (score_bcd),
    .best_bcd  (best_bcd),
    .cnt_data  (cnt_data),
    .state     (state),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One-cycle pulse on floor_inc followed by a low cycle.
  task automatic incPulse();
    floor_inc = 1'b1;
    tick();
    floor_inc = 1'b0;
    tick();
  endtask

  task automatic incMany(input int n);
    for (int i = 0; i < n; i++) incPulse();
  endtask

  task automatic startPulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic overPulse();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    start       = 1'b0;
    floor_inc   = 1'b0;
    game_over   = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (10) tick();

    // Reset state.
    checkOutput("rst_state", state, 16'h0000);
    checkOutput("rst_score", score_bcd, 16'h0000);
    checkOutput("rst_best", best_bcd, 16'h0000);
    checkOutput("rst_cnt", cnt_data, 16'h0000);
    checkOutput("rst_sat", sat, 16'h0000);

    // floor_inc ignored in IDLE.
    incPulse();
    checkOutput("idle_inc_score", score_bcd, 16'h0000);
    checkOutput("idle_inc_state", state, 16'h0000);

    // Start then 12 floors, 3 cycles apart.
    startPulse();
    checkOutput("start_state", state, 16'h0001);
    tick();
    for (int i = 0; i < 12; i++) begin
      floor_inc = 1'b1;
      tick();
      floor_inc = 1'b0;
      if (i != 11) repeat (2) tick();
    end
    checkOutput("inc12_score", score_bcd, 16'h0012);
    checkOutput("inc12_cnt_lag", cnt_data, 16'h0011);
    tick();
    checkOutput("inc12_cnt", cnt_data, 16'h0012);
    checkOutput("inc12_state", state, 16'h0001);

    // Held-high floor_inc counts once.
    floor_inc = 1'b1;
    repeat (20) tick();
    floor_inc = 1'b0;
    tick();
    checkOutput("held_inc", score_bcd, 16'h0013);

    // Carry ripples.
    incMany(86);
    checkOutput("to_0099", score_bcd, 16'h0099);
    incPulse();
    checkOutput("carry_0100", score_bcd, 16'h0100);
    incMany(899);
    checkOutput("to_0999", score_bcd, 16'h0999);
    incPulse();
    checkOutput("carry_1000", score_bcd, 16'h1000);

    // Saturation at 9999.
    startPulse();
    checkOutput("restart_score", score_bcd, 16'h0000);
    tick();
    incMany(9998);
    checkOutput("to_9998", score_bcd, 16'h9998);
    checkOutput("sat_9998", sat, 16'h0000);
    incPulse();
    checkOutput("reach_9999", score_bcd, 16'h9999);
    checkOutput("sat_reach", sat, 16'h0001);
    incMany(2);
    checkOutput("hold_9999", score_bcd, 16'h9999);
    checkOutput("sat_hold", sat, 16'h0001);
    startPulse();
    checkOutput("sat_restart_score", score_bcd, 16'h0000);
    checkOutput("sat_restart_sat", sat, 16'h0000);
    checkOutput("sat_restart_best", best_bcd, 16'h0000);
    tick();

    // Game over with a new best.
    incMany(37);
    checkOutput("to_0037", score_bcd, 16'h0037);
    overPulse();
    checkOutput("over1_state", state, 16'h0002);
    checkOutput("over1_best", best_bcd, 16'h0037);
    for (int k = 1; k <= 9; k++) begin
      tick();
      checkOutput("over1_cnt", cnt_data, 16'h0037);
    end

    // Lower score: best kept, display alternates.
    startPulse();
    checkOutput("restart2_state", state, 16'h0001);
    checkOutput("restart2_score", score_bcd, 16'h0000);
    tick();
    incMany(5);
    overPulse();
    checkOutput("over2_state", state, 16'h0002);
    checkOutput("over2_best", best_bcd, 16'h0037);
    checkOutput("over2_score", score_bcd, 16'h0005);
    for (int k = 1; k <= 12; k++) begin
      tick();
      checkOutput("over2_alt", cnt_data,
                  ((((k - 1) / 4) % 2) == 1) ? 16'h0037 : 16'h0005);
    end
    incPulse();
    checkOutput("over_inc_ignored", score_bcd, 16'h0005);
    checkOutput("over_inc_state", state, 16'h0002);

    // start beats game_over on the same edge.
    startPulse();
    tick();
    incMany(2);
    checkOutput("pre_pri_score", score_bcd, 16'h0002);
    start     = 1'b1;
    game_over = 1'b1;
    tick();
    start     = 1'b0;
    game_over = 1'b0;
    checkOutput("pri_start_state", state, 16'h0001);
    checkOutput("pri_start_score", score_bcd, 16'h0000);
    tick();

    // game_over beats floor_inc on the same edge.
    incMany(3);
    floor_inc = 1'b1;
    game_over = 1'b1;
    tick();
    floor_inc = 1'b0;
    game_over = 1'b0;
    checkOutput("pri_over_state", state, 16'h0002);
    checkOutput("pri_over_score", score_bcd, 16'h0003);
    checkOutput("pri_over_best", best_bcd, 16'h0037);
    tick();

    // Asynchronous reset mid-game.
    startPulse();
    tick();
    incMany(42);
    checkOutput("pre_rst_score", score_bcd, 16'h0042);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_state", state, 16'h0000);
    checkOutput("arst_score", score_bcd, 16'h0000);
    checkOutput("arst_best", best_bcd, 16'h0000);
    checkOutput("arst_cnt", cnt_data, 16'h0000);
    checkOutput("arst_sat", sat, 16'h0000);
    tick();
    rst = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/floor_bcd_scorer.md
Name: floor_bcd_scorer

Overview:
Score/floor-count stage directly upstream of the 4-digit seven-segment display driver. Receives game-event pulses from the game controller and keeps the current floor count and best score as 4-digit packed BCD. Drives the display's 16-bit digit bus `cnt_data`, with nibble [3:0] as the units digit. After game over, the display alternates between the last score and the best score.

Parameters:
- ALT_PERIOD, 50000000: clk cycles per half-period of the score/best alternation in OVER. Must be ≥ 2. The internal counter is sized to hold ALT_PERIOD-1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- start  input  1  game start/restart request (level; rising edge acts)
- floor_inc  input  1  player passed one floor (level; rising edge acts)
- game_over  input  1  player died (level; rising edge acts)
- score_bcd  output  16  current score, packed BCD, registered
- best_bcd  output  16  best score since reset, packed BCD, registered
- cnt_data  output  16  digit bus to the display driver, registered
- state  output  2  00 IDLE, 01 PLAY, 10 OVER
- sat  output  1  high while score_bcd is held at 9999

Behaviour:
- Reset (rst low, async) sets: state IDLE, score_bcd 0000, best_bcd 0000, cnt_data 0000, sat 0, alternation counter 0, show_best 0, all edge-detect registers 0.
  - Reset asserted mid-game discards the score and best immediately.
- Edge detect:
  - Each of start, floor_inc and game_over has a previous-value register.
  - An event is `in & ~in_prev`, evaluated at the clk edge.
  - The event takes effect at the first edge where the input is sampled high after being low.
  - A held-high input produces exactly one event.
- Event priority within one cycle: start > game_over > floor_inc. Lower-priority events in the same cycle are dropped.
- IDLE:
  - start → PLAY; score 0000; sat 0.
  - floor_inc and game_over are ignored.
  - cnt_data shows best_bcd.
- PLAY:
  - floor_inc increments score by one in BCD:
    - Units digit 9 wraps to 0 and carries into tens; the carry ripples through all four digits.
    - Each digit stays within 0-9 at all times.
  - Saturation:
    - At 9999, floor_inc leaves score unchanged and sets sat=1.
    - sat is also set on the increment that reaches 9999.
  - game_over → OVER. On the same edge, best_bcd becomes score_bcd if score_bcd > best_bcd. The comparison is unsigned on the 16-bit packed value, which preserves BCD order. Equal values leave best_bcd unchanged.
  - start restarts: score 0000, sat 0, state stays PLAY, best unchanged.
  - cnt_data shows score_bcd.
- OVER:
  - On entry, the counter is 0 and show_best is 0.
  - The counter increments every cycle. At ALT_PERIOD-1 it wraps to 0 and toggles show_best.
  - cnt_data shows best_bcd when show_best=1, otherwise score_bcd.
  - floor_inc and game_over are ignored.
  - start → PLAY; score 0000; sat 0; counter and show_best cleared.
- Latency:
  - score_bcd, best_bcd, state and sat update on the event edge.
  - cnt_data is registered from the post-update selection and lags those outputs by one cycle.
- No other state transitions exist. An undefined state encoding recovers to IDLE on the next edge.

Test Plan:
- Reset release then idle 10 cycles → state=00, score=0000, best=0000, cnt_data=0000, sat=0.
- start pulse, then 12 floor_inc pulses of 1 cycle each, 3 cycles apart → score=0012 (0x0012); cnt_data=0x0012 one cycle after the last score update; state=01.
- Hold floor_inc high 20 cycles in PLAY → score increments by exactly 1. From 0x0099 one inc → 0x0100. From 0x0999 one inc → 0x1000.
- Preload 9998 via 9998 incs, then 3 more incs → score=0x9999, sat=1 from the increment that reached 9999, no wrap. start → score=0000, sat=0.
- ALT_PERIOD=4: score 0x0037, game_over → best=0x0037, state=10. cnt_data shows 0x0037, then 0x0037 for the best phase as well. Restart, reach score 0x0005, game_over → best stays 0x0037. cnt_data alternates 0x0005 / 0x0037 every 4 cycles.
- start and game_over rising on the same edge in PLAY → restart wins: state=01, score=0000. floor_inc and game_over on the same edge → OVER with the un-incremented score. rst pulled low mid-PLAY with score 0x0042 → all outputs 0 asynchronously.
